// File: rtl/one_wire_pkg.sv
// ---------------------------------------------------------------------------
// one_wire_pkg
// Shared definitions for the 1-Wire bus master:
//   op_e         command opcodes carried on cmd_op
//   state_e      master sequencer states
//   CRC_POLY     reflected Dallas/Maxim CRC-8 polynomial
//   us2cyc()     converts a microsecond figure into clk cycles
// ---------------------------------------------------------------------------
package one_wire_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_TRIPLET = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_SLOT_LOW,
    S_SLOT_WAIT,
    S_REC,
    S_DONE
  } state_e;

  localparam logic [7:0] CRC_POLY = 8'h8C;

  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned mhz);
    return us * mhz;
  endfunction

endpackage

// File: rtl/one_wire_master_if.sv
// ---------------------------------------------------------------------------
// one_wire_master_if
// Command / response channel between the register bank and the 1-Wire master.
//   cmd_valid/cmd_ready  request handshake (op, nbits, data, dir)
//   rsp_valid            one-cycle completion pulse; rsp_* hold afterwards
//   rsp_data/presence/crc/crc_ok/trip/err  result fields
// Modports: master (the bus engine), slave (the command issuer).
// ---------------------------------------------------------------------------
interface one_wire_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_nbits;
  logic [63:0] cmd_data;
  logic        cmd_dir;

  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_presence;
  logic [7:0]  rsp_crc;
  logic        rsp_crc_ok;
  logic [2:0]  rsp_trip;
  logic        rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_nbits, cmd_data, cmd_dir,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc,
           rsp_crc_ok, rsp_trip, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_nbits, cmd_data, cmd_dir,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc,
           rsp_crc_ok, rsp_trip, rsp_err
  );
endinterface

// File: rtl/one_wire_crc8.sv
// ---------------------------------------------------------------------------
// one_wire_crc8
// Bit-serial Dallas CRC-8 (reflected polynomial 0x8C), one bit per enabled cycle.
//   clk     clock
//   clr     synchronous clear to 0x00 (has priority over en)
//   en      consume bit_in this cycle
//   bit_in  next received bit, LSB first
//   crc     running remainder
// ---------------------------------------------------------------------------
module one_wire_crc8
  import one_wire_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic mix;

  assign mix = crc[0] ^ bit_in;

  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= (crc >> 1) ^ (mix ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/one_wire_master.sv
// ---------------------------------------------------------------------------
// one_wire_master
// 1-Wire bus master: RESET/presence, WRITE and READ of 1..64 bits LSB first,
// ROM-search TRIPLET, CRC-8 over read bits, error reporting.
//   clk, reset   clock and synchronous active-high reset
//   bus          command/response channel (one_wire_master_if.master)
//   ow_oe        1 = pull the open-drain line low
//   ow_in        asynchronous bus level, synchronised internally
// All timing parameters are in microseconds and scaled by CLK_MHZ.
// ---------------------------------------------------------------------------
module one_wire_master
  import one_wire_pkg::*;
#(
  parameter int unsigned CLK_MHZ     = 24,
  parameter int unsigned T_RSTL_US   = 480,
  parameter int unsigned T_RSTH_US   = 480,
  parameter int unsigned T_PDI_US    = 70,
  parameter int unsigned T_LOW0_US   = 60,
  parameter int unsigned T_LOW1_US   = 6,
  parameter int unsigned T_SAMPLE_US = 12,
  parameter int unsigned T_SLOT_US   = 70,
  parameter int unsigned T_REC_US    = 2
) (
  input  logic              clk,
  input  logic              reset,
  one_wire_master_if.master bus,
  output logic              ow_oe,
  input  logic              ow_in
);

  localparam int unsigned C_RSTL   = us2cyc(T_RSTL_US, CLK_MHZ);
  localparam int unsigned C_RSTH   = us2cyc(T_RSTH_US, CLK_MHZ);
  localparam int unsigned C_PDI    = us2cyc(T_PDI_US, CLK_MHZ);
  localparam int unsigned C_LOW0   = us2cyc(T_LOW0_US, CLK_MHZ);
  localparam int unsigned C_LOW1   = us2cyc(T_LOW1_US, CLK_MHZ);
  localparam int unsigned C_SAMPLE = us2cyc(T_SAMPLE_US, CLK_MHZ);
  localparam int unsigned C_SLOT   = us2cyc(T_SLOT_US, CLK_MHZ);
  localparam int unsigned C_REC    = us2cyc(T_REC_US, CLK_MHZ);

  localparam int unsigned C_M0  = (C_RSTL > C_RSTH) ? C_RSTL : C_RSTH;
  localparam int unsigned C_M1  = (C_M0 > C_SLOT) ? C_M0 : C_SLOT;
  localparam int unsigned C_M2  = (C_M1 > C_LOW0) ? C_M1 : C_LOW0;
  localparam int unsigned C_MAX = (C_M2 > C_REC) ? C_M2 : C_REC;
  localparam int          CW    = $clog2(C_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;

  state_e      state, state_d;
  cnt_t        cnt, cnt_d;

  op_e         op_q;
  logic [6:0]  nbits_q;
  logic [63:0] data_q;
  logic        dir_q;
  logic [6:0]  bit_n;

  logic        ow_meta, ow_sync;

  logic [63:0] rsp_data_q;
  logic        presence_q;
  logic [2:0]  trip_q;
  logic        err_q;
  logic        have_result;
  logic [7:0]  crc;

  op_e         cmd_op_e;
  logic        accept;
  logic        len_bad;
  logic        write_bit;
  cnt_t        low_len;
  logic        sample_pt;
  logic        rec_end;
  logic        last_slot;
  logic        trip_stop;
  logic        dir_calc;

  assign cmd_op_e = op_e'(bus.cmd_op);
  assign accept   = (state == S_IDLE) && bus.cmd_valid;
  assign len_bad  = ((cmd_op_e == OP_WRITE) || (cmd_op_e == OP_READ)) &&
                    ((bus.cmd_nbits == 7'd0) || (bus.cmd_nbits > 7'd64));

  // Reads and TRIPLET id/cmp slots behave like writing a 1 (short low pulse).
  always_comb begin
    write_bit = 1'b1;
    if (op_q == OP_WRITE) begin
      write_bit = data_q[bit_n[5:0]];
    end else if ((op_q == OP_TRIPLET) && (bit_n == 7'd2)) begin
      write_bit = trip_q[2];
    end
  end

  assign low_len   = write_bit ? cnt_t'(C_LOW1) : cnt_t'(C_LOW0);
  assign sample_pt = ((state == S_SLOT_LOW) || (state == S_SLOT_WAIT)) &&
                     (cnt == cnt_t'(C_SAMPLE));
  assign rec_end   = (state == S_REC) && (cnt == cnt_t'(C_REC - 1));
  assign trip_stop = trip_q[0] & trip_q[1];
  assign dir_calc  = (trip_q[0] != trip_q[1]) ? trip_q[0] : dir_q;
  assign last_slot = (op_q == OP_TRIPLET) ?
                     ((bit_n == 7'd2) || ((bit_n == 7'd1) && trip_stop)) :
                     (bit_n == (nbits_q - 7'd1));

  // Stage: bus input synchroniser
  always_ff @(posedge clk) begin
    ow_meta <= ow_in;
    ow_sync <= ow_meta;
  end

  // Stage: sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // The slot counter runs straight through SLOT_LOW into SLOT_WAIT so that
  // the sample point and slot end are both measured from slot start.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + cnt_t'(1);
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.cmd_valid) begin
          if (cmd_op_e == OP_RESET) state_d = S_RST_LOW;
          else if (len_bad)         state_d = S_DONE;
          else                      state_d = S_SLOT_LOW;
        end
      end
      S_RST_LOW: begin
        if (cnt == cnt_t'(C_RSTL - 1)) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
        end
      end
      S_RST_WAIT: begin
        if (cnt == cnt_t'(C_RSTH)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_SLOT_LOW: begin
        if (cnt == (low_len - cnt_t'(1))) state_d = S_SLOT_WAIT;
      end
      S_SLOT_WAIT: begin
        if (cnt == cnt_t'(C_SLOT - 1)) begin
          state_d = S_REC;
          cnt_d   = '0;
        end
      end
      S_REC: begin
        if (cnt == cnt_t'(C_REC - 1)) begin
          cnt_d   = '0;
          state_d = last_slot ? S_DONE : S_SLOT_LOW;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage: command latch, bus driver and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ow_oe       <= 1'b0;
      rsp_data_q  <= '0;
      presence_q  <= 1'b0;
      trip_q      <= '0;
      err_q       <= 1'b0;
      have_result <= 1'b0;
    end else begin
      ow_oe       <= (state_d == S_RST_LOW) || (state_d == S_SLOT_LOW);
      have_result <= (state_d == S_DONE) || (have_result && !accept);

      if (accept) begin
        op_q       <= cmd_op_e;
        nbits_q    <= bus.cmd_nbits;
        data_q     <= bus.cmd_data;
        dir_q      <= bus.cmd_dir;
        bit_n      <= '0;
        rsp_data_q <= '0;
        presence_q <= 1'b0;
        trip_q     <= '0;
        err_q      <= len_bad;
      end

      if ((state == S_RST_WAIT) && (cnt == cnt_t'(C_PDI))) begin
        presence_q <= ~ow_sync;
      end

      if (sample_pt) begin
        if (op_q == OP_READ) begin
          rsp_data_q[bit_n[5:0]] <= ow_sync;
        end else if (op_q == OP_TRIPLET) begin
          if (bit_n == 7'd0) trip_q[0] <= ow_sync;
          if (bit_n == 7'd1) trip_q[1] <= ow_sync;
        end
      end

      // After the cmp slot, either pick the search direction or flag that
      // no device answered (both id and cmp read as 1).
      if (rec_end) begin
        bit_n <= bit_n + 7'd1;
        if ((op_q == OP_TRIPLET) && (bit_n == 7'd1)) begin
          if (trip_stop) err_q     <= 1'b1;
          else           trip_q[2] <= dir_calc;
        end
      end
    end
  end

  one_wire_crc8 u_crc (
    .clk    (clk),
    .clr    (reset || accept),
    .en     (sample_pt && (op_q == OP_READ)),
    .bit_in (ow_sync),
    .crc    (crc)
  );

  assign bus.cmd_ready    = (state == S_IDLE);
  assign bus.rsp_valid    = (state == S_DONE);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_presence = presence_q;
  assign bus.rsp_crc      = crc;
  assign bus.rsp_crc_ok   = have_result && (crc == 8'h00);
  assign bus.rsp_trip     = trip_q;
  assign bus.rsp_err      = err_q;

endmodule

// File: tb/tb_one_wire_master.sv
// ---------------------------------------------------------------------------
// tb_one_wire_master
// Directed bench for one_wire_master at CLK_MHZ=24 with a behavioural 1-Wire
// device (presence responder / bit sender) and an ow_oe pulse monitor.
// ---------------------------------------------------------------------------
module tb_one_wire_master;
  import one_wire_pkg::*;

  localparam int DEV_NONE = 0;
  localparam int DEV_PRES = 1;
  localparam int DEV_READ = 2;

  logic clk = 1'b0;
  logic reset;
  logic ow_oe;
  logic ow_in;
  logic dev_low = 1'b0;

  always #5 clk = ~clk;

  one_wire_master_if bus ();

  one_wire_master #(.CLK_MHZ(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ow_oe (ow_oe),
    .ow_in (ow_in)
  );

  // Open-drain line with pull-up: low if master or device pulls it.
  assign ow_in = ~ow_oe & ~dev_low;

  int          dev_mode;
  logic [63:0] tx_bits;
  int          rd_base;
  int          slot_cnt = 0;

  // Device model: on each master low pulse, either send the next bit
  // (hold low 30 us for a 0) or, after a reset pulse, answer with presence.
  initial begin
    int idx;
    forever begin
      @(posedge ow_oe);
      if (dev_mode == DEV_READ) begin
        idx = slot_cnt - rd_base;
        slot_cnt++;
        if (!tx_bits[idx[5:0]]) begin
          dev_low = 1'b1;
          repeat (720) @(posedge clk);
          dev_low = 1'b0;
        end
      end else if (dev_mode == DEV_PRES) begin
        @(negedge ow_oe);
        repeat (360) @(posedge clk);
        dev_low = 1'b1;
        repeat (5400) @(posedge clk);
        dev_low = 1'b0;
      end
    end
  end

  // ow_oe monitor: lengths of low pulses and the cycle each one starts.
  int   pulses[$];
  int   rises[$];
  int   run = 0;
  int   ncyc = 0;
  logic oe_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (ow_oe) begin
        if (!oe_prev) rises.push_back(ncyc);
        run++;
      end else if (oe_prev) begin
        pulses.push_back(run);
        run = 0;
      end
      oe_prev = ow_oe;
    end
  end

  function automatic int pulse_at(input int i);
    if (i < pulses.size()) return pulses[i];
    return -1;
  endfunction

  function automatic int rise_at(input int i);
    if (i < rises.size()) return rises[i];
    return -1;
  endfunction

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a command on a falling edge and hold it until accepted.
  task automatic send_cmd(input logic [1:0] op, input logic [6:0] nb,
                          input logic [63:0] d, input logic dir);
    int k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_nbits = nb;
    bus.cmd_data  = d;
    bus.cmd_dir   = dir;
    k = 0;
    while (!bus.cmd_ready && (k < 10)) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Count falling edges after the accept edge until rsp_valid; -1 on timeout.
  task automatic wait_rsp(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    int rbase;
    int seen;
    int exp_w[8];

    exp_w = '{144, 1440, 144, 1440, 1440, 144, 1440, 144};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_nbits = 7'd0;
    bus.cmd_data  = 64'd0;
    bus.cmd_dir   = 1'b0;
    dev_mode      = DEV_NONE;
    tx_bits       = 64'd0;
    rd_base       = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_ow_oe", 64'(ow_oe), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_presence", 64'(bus.rsp_presence), 64'd0);
    chk("rst_rsp_crc", 64'(bus.rsp_crc), 64'd0);
    chk("rst_rsp_crc_ok", 64'(bus.rsp_crc_ok), 64'd0);
    chk("rst_rsp_trip", 64'(bus.rsp_trip), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bus RESET with a device answering presence
    dev_mode = DEV_PRES;
    base = pulses.size();
    send_cmd(OP_RESET, 7'd0, 64'd0, 1'b0);
    wait_rsp(24000, lat);
    chk("busrst_latency", 64'(lat), 64'd23042);
    chk("busrst_presence", 64'(bus.rsp_presence), 64'd1);
    chk("busrst_err", 64'(bus.rsp_err), 64'd0);
    chk("busrst_pulse_count", 64'(pulses.size() - base), 64'd1);
    chk("busrst_pulse_len", 64'(pulse_at(base)), 64'd11520);
    chk("busrst_ready_in_done", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    chk("busrst_valid_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Bus RESET with nobody on the bus; abort once presence has been sampled
    dev_mode = DEV_NONE;
    send_cmd(OP_RESET, 7'd0, 64'd0, 1'b0);
    repeat (11520 + 1690) @(negedge clk);
    chk("nodev_presence", 64'(bus.rsp_presence), 64'd0);
    chk("nodev_busy", 64'(bus.cmd_ready), 64'd0);
    chk("nodev_released", 64'(ow_oe), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("nodev_abort_ready", 64'(bus.cmd_ready), 64'd1);

    // WRITE 8 bits of 0xA5
    base  = pulses.size();
    rbase = rises.size();
    send_cmd(OP_WRITE, 7'd8, 64'hA5, 1'b0);
    wait_rsp(15000, lat);
    chk("wr_latency", 64'(lat), 64'd13825);
    chk("wr_err", 64'(bus.rsp_err), 64'd0);
    chk("wr_pulse_count", 64'(pulses.size() - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_pulse%0d", i), 64'(pulse_at(base + i)), 64'(exp_w[i]));
    end
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wr_spacing%0d", i),
          64'(rise_at(rbase + i) - rise_at(rbase + i - 1)), 64'd1728);
    end

    // READ 16 bits, device sends 0x5E01 (first byte 0x01 has CRC 0x5E)
    dev_mode = DEV_READ;
    rd_base  = slot_cnt;
    tx_bits  = 64'h5E01;
    send_cmd(OP_READ, 7'd16, 64'd0, 1'b0);
    repeat (8 * 1728) @(negedge clk);
    chk("rd8_crc", 64'(bus.rsp_crc), 64'h5E);
    chk("rd8_data", bus.rsp_data, 64'h01);
    wait_rsp(15000, lat);
    chk("rd16_latency_tail", 64'(lat), 64'd13825);
    chk("rd16_data", bus.rsp_data, 64'h5E01);
    chk("rd16_crc", 64'(bus.rsp_crc), 64'h00);
    chk("rd16_crc_ok", 64'(bus.rsp_crc_ok), 64'd1);
    chk("rd16_err", 64'(bus.rsp_err), 64'd0);

    // TRIPLET: id=0 cmp=0, cmd_dir=1 -> direction 1 written
    rd_base = slot_cnt;
    tx_bits = 64'b100;
    base    = pulses.size();
    send_cmd(OP_TRIPLET, 7'd0, 64'd0, 1'b1);
    wait_rsp(6000, lat);
    chk("trip00_latency", 64'(lat), 64'd5185);
    chk("trip00_trip", 64'(bus.rsp_trip), 64'b100);
    chk("trip00_err", 64'(bus.rsp_err), 64'd0);
    chk("trip00_slots", 64'(pulses.size() - base), 64'd3);
    chk("trip00_write_slot", 64'(pulse_at(base + 2)), 64'd144);

    // TRIPLET: id=1 cmp=0 -> direction follows id regardless of cmd_dir
    rd_base = slot_cnt;
    tx_bits = 64'b101;
    base    = pulses.size();
    send_cmd(OP_TRIPLET, 7'd0, 64'd0, 1'b0);
    wait_rsp(6000, lat);
    chk("trip10_trip", 64'(bus.rsp_trip), 64'b101);
    chk("trip10_err", 64'(bus.rsp_err), 64'd0);
    chk("trip10_slots", 64'(pulses.size() - base), 64'd3);
    chk("trip10_write_slot", 64'(pulse_at(base + 2)), 64'd144);

    // TRIPLET: id=1 cmp=1 -> error, third slot skipped
    rd_base = slot_cnt;
    tx_bits = 64'b011;
    base    = pulses.size();
    send_cmd(OP_TRIPLET, 7'd0, 64'd0, 1'b0);
    wait_rsp(6000, lat);
    chk("trip11_latency", 64'(lat), 64'd3457);
    chk("trip11_err", 64'(bus.rsp_err), 64'd1);
    chk("trip11_slots", 64'(pulses.size() - base), 64'd2);

    // Illegal lengths: immediate completion with error, no bus activity
    dev_mode = DEV_NONE;
    base = pulses.size();
    send_cmd(OP_WRITE, 7'd0, 64'hFF, 1'b0);
    wait_rsp(5, lat);
    chk("len0_fast", 64'((lat >= 1) && (lat <= 2)), 64'd1);
    chk("len0_err", 64'(bus.rsp_err), 64'd1);
    chk("len0_oe", 64'(ow_oe), 64'd0);
    send_cmd(OP_WRITE, 7'd65, 64'hFF, 1'b0);
    wait_rsp(5, lat);
    chk("len65_fast", 64'((lat >= 1) && (lat <= 2)), 64'd1);
    chk("len65_err", 64'(bus.rsp_err), 64'd1);
    @(negedge clk);
    chk("len_no_pulses", 64'(pulses.size() - base), 64'd0);
    chk("len_oe_idle", 64'(ow_oe), 64'd0);

    // Reset in the middle of a write-0 slot
    send_cmd(OP_WRITE, 7'd1, 64'd0, 1'b0);
    repeat (500) @(negedge clk);
    chk("midrst_oe_before", 64'(ow_oe), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_oe", 64'(ow_oe), 64'd0);
    chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);

    // READ of one bit afterwards completes normally (bit 1 -> CRC 0x8C)
    dev_mode = DEV_READ;
    rd_base  = slot_cnt;
    tx_bits  = 64'h1;
    send_cmd(OP_READ, 7'd1, 64'd0, 1'b0);
    wait_rsp(2500, lat);
    chk("post_rd_latency", 64'(lat), 64'd1729);
    chk("post_rd_data", bus.rsp_data, 64'h1);
    chk("post_rd_crc", 64'(bus.rsp_crc), 64'h8C);
    chk("post_rd_crc_ok", 64'(bus.rsp_crc_ok), 64'd0);
    chk("post_rd_err", 64'(bus.rsp_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
